// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the RV32 pipeline hazard logic.
//   state_t   : sequencer states (RUN, MC_WAIT)
//   FWD_*     : EX-stage operand forwarding selects
//   RES_LOAD  : ResultSrc encoding of a load in EX
//   fwd_sel() : forwarding select for one EX source register
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

    // MEM holds the younger result, so it wins over WB. x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Purely combinational forwarding selects and load-use hazard detection.
//   Rs1D, Rs2D            : ID source registers
//   Rs1E, Rs2E, RdE       : EX source / destination registers
//   ResultSrcE            : EX result source (RES_LOAD = load)
//   RdM, RegWriteM        : MEM destination / write enable
//   RdW, RegWriteW        : WB destination / write enable
//   ForwardAE, ForwardBE  : operand selects for EX (FWD_RF / FWD_WB / FWD_MEM)
//   lw_stall              : load in EX feeds an instruction in ID
// -----------------------------------------------------------------------------
module hazard_fwd_unit
    import cpu_pkg::*;
(
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       lw_stall
);

    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    // A load result is not available until MEM, so a dependent ID instruction
    // must wait one cycle; loads into x0 never create a dependency.
    assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

endmodule

// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
// Pipeline controller for the 5-stage RV32 core: stall/flush control for the
// IF/ID, ID/EX and EX/MEM registers, EX forwarding selects, a start/done
// sequencer with timeout for multi-cycle EX ops, and saturating debug counters.
//   clk, n_rst                 : clock, asynchronous active-low reset
//   Rs1D..RegWriteW            : hazard-detection inputs from ID/EX/MEM/WB
//   McOpE, mc_done             : multi-cycle op in EX / unit result valid
//   PCSrcE                     : taken branch/jump resolved in EX
//   cnt_clr                    : synchronous counter clear
//   StallF/D/E, FlushD/E/M     : pipeline register controls
//   ForwardAE, ForwardBE       : EX operand selects
//   mc_start                   : one-cycle start pulse to the multi-cycle unit
//   mc_err                     : sticky multi-cycle timeout flag
//   stall_cnt, flush_cnt       : saturating event counters
// -----------------------------------------------------------------------------
module hazard_sequencer
    import cpu_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             McOpE,
    input  logic             mc_done,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             cnt_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mc_start,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TMR_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nx;
    logic [TMR_W-1:0] timer;
    logic             lw_stall;
    logic             timeout;
    logic             stall_f_c, stall_d_c, stall_e_c;
    logic             flush_d_c, flush_e_c, flush_m_c;
    logic             mc_start_c;

    hazard_fwd_unit u_fwd (
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .ResultSrcE (ResultSrcE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .lw_stall   (lw_stall)
    );

    assign timeout = (timer == TMR_LAST);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. A branch in EX squashes a would-be multi-cycle issue;
    // mc_done wins over a coincident timeout.
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (McOpE && !PCSrcE)    state_nx = MC_WAIT;
            MC_WAIT: if (mc_done || timeout) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Output logic.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        stall_e_c  = 1'b0;
        flush_d_c  = 1'b0;
        flush_e_c  = 1'b0;
        flush_m_c  = 1'b0;
        mc_start_c = 1'b0;
        case (state)
            RUN: begin
                if (McOpE && !PCSrcE) begin
                    // Freeze the front end with the op held in EX; bubble MEM.
                    mc_start_c = 1'b1;
                    stall_f_c  = 1'b1;
                    stall_d_c  = 1'b1;
                    stall_e_c  = 1'b1;
                    flush_m_c  = 1'b1;
                end else if (PCSrcE) begin
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end else if (lw_stall) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end
            end
            MC_WAIT: begin
                // Release in the done/timeout cycle so the EX result advances.
                if (!(mc_done || timeout)) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    flush_m_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs are forced low while reset is held, even though the FSM decode
    // would otherwise react to McOpE/PCSrcE combinationally in RUN.
    assign StallF   = n_rst & stall_f_c;
    assign StallD   = n_rst & stall_d_c;
    assign StallE   = n_rst & stall_e_c;
    assign FlushD   = n_rst & flush_d_c;
    assign FlushE   = n_rst & flush_e_c;
    assign FlushM   = n_rst & flush_m_c;
    assign mc_start = n_rst & mc_start_c;

    // Wait timer and sticky timeout flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer  <= '0;
            mc_err <= 1'b0;
        end else begin
            if ((state == MC_WAIT) && (state_nx == MC_WAIT)) begin
                timer <= timer + TMR_ONE;
            end else begin
                timer <= '0;
            end
            if ((state == MC_WAIT) && timeout && !mc_done) begin
                mc_err <= 1'b1;
            end
        end
    end

    // Saturating debug counters; clear has priority over counting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f_c && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if ((flush_d_c || flush_e_c) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
// Directed stimulus with hand-computed per-cycle expectations pushed into a
// scoreboard queue; a negedge monitor pops and compares the full output vector
// {StallF,StallD,StallE,FlushD,FlushE,FlushM,mc_start,mc_err,ForwardAE,
//  ForwardBE,stall_cnt,flush_cnt}. Runs with MC_TIMEOUT = 8 and CNT_W = 4.
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 4;

    // {StallF,StallD,StallE,FlushD,FlushE,FlushM}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LW   = 6'b110010;
    localparam logic [5:0] BR   = 6'b000110;
    localparam logic [5:0] MC   = 6'b111001;

    typedef struct {
        string       nm;
        logic [19:0] v;
    } exp_t;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             McOpE, mc_done, PCSrcE, RegWriteM, RegWriteW, cnt_clr;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mc_start, mc_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] m_scnt = '0;
    logic [3:0] m_fcnt = '0;
    logic       m_err  = 1'b0;

    always #5 clk = ~clk;

    hazard_sequencer #(
        .MC_TIMEOUT (MC_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .ResultSrcE (ResultSrcE),
        .McOpE      (McOpE),
        .mc_done    (mc_done),
        .PCSrcE     (PCSrcE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .cnt_clr    (cnt_clr),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .mc_start   (mc_start),
        .mc_err     (mc_err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    function automatic logic [19:0] act_vec();
        return {StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_start, mc_err,
                ForwardAE, ForwardBE, stall_cnt, flush_cnt};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE = '0; McOpE = 0; mc_done = 0; PCSrcE = 0;
        RegWriteM = 0; RegWriteW = 0; cnt_clr = 0;
    endtask

    // Queue the expectation for the current cycle, advance the counter model
    // by this cycle's events, then move to just after the next rising edge.
    task automatic push(input string nm, input logic [5:0] sf, input logic st,
                        input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.nm = nm;
        e.v  = {sf, st, m_err, fa, fb, m_scnt, m_fcnt};
        q.push_back(e);
        if (cnt_clr) begin
            m_scnt = '0;
            m_fcnt = '0;
        end else begin
            if (sf[5] && m_scnt != 4'hF) m_scnt = m_scnt + 4'd1;
            if ((sf[2] || sf[1]) && m_fcnt != 4'hF) m_fcnt = m_fcnt + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mc_issue(input string nm);
        idle(); McOpE = 1; push(nm, MC, 1'b1, 2'b00, 2'b00);
    endtask

    task automatic mc_wait(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            idle(); McOpE = 1; push(nm, MC, 1'b0, 2'b00, 2'b00);
        end
    endtask

    // Monitor: compare whenever an expectation is pending.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.nm, {12'h0, act_vec()}, {12'h0, e.v});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: McOpE high shows the start pulse is held off during reset.
        idle();
        n_rst = 1'b0;
        McOpE = 1;
        #3;
        check("reset_outputs", {12'h0, act_vec()}, 32'h0);
        McOpE = 0;
        #9 n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Forwarding.
        idle(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        push("fwd_mem_over_wb", NONE, 0, 2'b10, 2'b00);
        idle(); RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1; Rs1E = 0;
        push("fwd_x0", NONE, 0, 2'b00, 2'b00);
        idle(); Rs2E = 7; RdW = 7; RegWriteW = 1; RdM = 2; RegWriteM = 1; Rs1E = 2;
        push("fwd_b_wb", NONE, 0, 2'b10, 2'b01);
        idle(); RdM = 9; RegWriteM = 0; RdW = 9; RegWriteW = 1; Rs1E = 9; Rs2E = 9;
        push("fwd_mem_we_off", NONE, 0, 2'b01, 2'b01);

        // Load-use.
        idle(); ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        push("lw_rd_x0", NONE, 0, 2'b00, 2'b00);
        idle(); ResultSrcE = 2'b10; RdE = 3; Rs2D = 3;
        push("non_load_no_stall", NONE, 0, 2'b00, 2'b00);
        idle(); ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        push("lw_stall", LW, 0, 2'b00, 2'b00);
        idle();
        push("lw_released", NONE, 0, 2'b00, 2'b00);

        // Branch priority.
        idle(); PCSrcE = 1; ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
        push("branch_over_lw", BR, 0, 2'b00, 2'b00);
        idle(); PCSrcE = 1; McOpE = 1;
        push("branch_over_mc", BR, 0, 2'b00, 2'b00);

        // Multi-cycle op, done after 5 cycles; branch/lw ignored while waiting.
        mc_issue("mc1_issue");
        mc_wait("mc1_wait", 1);
        idle(); McOpE = 1; PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        push("mc1_wait_ignores_hazards", MC, 0, 2'b00, 2'b00);
        mc_wait("mc1_wait", 2);
        idle(); McOpE = 1; mc_done = 1;
        push("mc1_done_release", NONE, 0, 2'b00, 2'b00);
        idle(); mc_done = 1;
        push("mc1_done_ignored_in_run", NONE, 0, 2'b00, 2'b00);

        // Done coinciding with the last timer value: no error.
        mc_issue("mc2_issue");
        mc_wait("mc2_wait", MC_TIMEOUT - 1);
        idle(); McOpE = 1; mc_done = 1;
        push("mc2_done_at_timeout", NONE, 0, 2'b00, 2'b00);
        idle();
        push("mc2_no_err", NONE, 0, 2'b00, 2'b00);

        // Timeout: release after 8 cycles in MC_WAIT, error sticky.
        mc_issue("mc3_issue");
        mc_wait("mc3_wait", MC_TIMEOUT - 1);
        idle(); McOpE = 1;
        push("mc3_timeout_release", NONE, 0, 2'b00, 2'b00);
        m_err = 1'b1;
        idle();
        push("mc3_err_set", NONE, 0, 2'b00, 2'b00);
        mc_issue("mc4_issue_err_sticky");
        idle(); McOpE = 1; mc_done = 1;
        push("mc4_done", NONE, 0, 2'b00, 2'b00);
        idle();
        push("mc4_err_still_set", NONE, 0, 2'b00, 2'b00);

        // Counters: clear wins over a simultaneous event, then saturation.
        idle(); cnt_clr = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        push("cnt_clr_wins", LW, 0, 2'b00, 2'b00);
        idle();
        push("cnt_cleared", NONE, 0, 2'b00, 2'b00);
        for (int i = 0; i < 20; i++) begin
            idle(); ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
            push("lw_held", LW, 0, 2'b00, 2'b00);
        end
        idle();
        push("cnt_saturated", NONE, 0, 2'b00, 2'b00);

        // Reset in the middle of MC_WAIT.
        mc_issue("mc5_issue");
        mc_wait("mc5_wait", 2);
        idle(); McOpE = 1;
        #2 n_rst = 1'b0;
        #1 check("reset_mid_wait", {12'h0, act_vec()}, 32'h0);
        m_scnt = '0;
        m_fcnt = '0;
        m_err  = 1'b0;
        McOpE  = 0;
        #2 n_rst = 1'b1;
        @(posedge clk);
        #1;
        idle();
        push("run_after_reset", NONE, 0, 2'b00, 2'b00);
        mc_issue("mc6_issue_after_reset");
        idle(); McOpE = 1; mc_done = 1;
        push("mc6_done", NONE, 0, 2'b00, 2'b00);
        idle();
        push("mc6_idle", NONE, 0, 2'b00, 2'b00);

        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
